mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu_if.sv | 27 ++
 rtl/mc_alu.sv | 174 +++++++++++++++++
 tb/tb_mc_alu.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mc_alu_if.sv
// rtl/mc_alu_if.sv - request/response bundle for the multicycle ALU
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             carry_in;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry_out;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, op, operandA, operandB, carry_in,
        input  result, result_hi, zero, carry_out, busy, done, div0
    );

    modport slave (
        input  start, op, operandA, operandB, carry_in,
        output result, result_hi, zero, carry_out, busy, done, div0
    );
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - ALU with single-cycle logic/add ops and multicycle MULU/DIVU
// Optional divider: define MC_ALU_DIV_EN; otherwise DIVU completes in one cycle with zero results.
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mc_alu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MULU  = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_reg, lo_reg, a_reg;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH-1:0] result_r, result_hi_r;
    logic             zero_r, carry_out_r, div0_r, div0_n;
    logic             accept, accept_div, is_multi;

    assign accept   = bus.start && (state != RUN);
    assign is_multi = (bus.op == OP_MULU) || accept_div;

    // Single-cycle datapath; SUB and SLT share the inverted-operand adder
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sc_res;
    logic             sc_co;

    always_comb begin
        sub_mode = (bus.op == OP_SUB) || (bus.op == OP_SLT);
        b_eff    = sub_mode ? ~bus.operandB : bus.operandB;
        c_eff    = sub_mode ? ~bus.carry_in : bus.carry_in;
        add_full = {1'b0, bus.operandA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
        sc_res   = bus.operandA & bus.operandB;
        sc_co    = 1'b0;
        case (bus.op)
            OP_OR:    sc_res = bus.operandA | bus.operandB;
            OP_ADD, OP_SUB: begin
                sc_res = add_full[WIDTH-1:0];
                sc_co  = add_full[WIDTH];
            end
            OP_SLT: begin
                sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.operandA) < $signed(bus.operandB)};
                sc_co  = add_full[WIDTH];
            end
            OP_PASSB: sc_res = bus.operandB;
            OP_DIVU:  sc_res = '0;
            default:  sc_res = bus.operandA & bus.operandB;
        endcase
    end

    // Shift-add multiply: hi accumulates, lo holds the multiplier shifting out
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end

`ifdef MC_ALU_DIV_EN
    // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in
    logic             is_div;
    logic [WIDTH:0]   shifted, diff;

    assign accept_div = (bus.op == OP_DIVU);

    always_comb begin
        shifted = {hi_reg, lo_reg[WIDTH-1]};
        diff    = shifted - {1'b0, a_reg};
        hi_n    = mul_hi_n;
        lo_n    = mul_lo_n;
        if (is_div) begin
            hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n = {lo_reg[WIDTH-2:0], ~diff[WIDTH]};
        end
        div0_n = is_div && (a_reg == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            is_div <= 1'b0;
        else if (accept)
            is_div <= accept_div;
    end
`else
    assign accept_div = 1'b0;
    assign hi_n       = mul_hi_n;
    assign lo_n       = mul_lo_n;
    assign div0_n     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start)
                    next_state = is_multi ? RUN : DONE;
                else if (state == DONE)
                    next_state = IDLE;
            end
            RUN:     if (cnt == LAST) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            a_reg       <= '0;
            result_r    <= '0;
            result_hi_r <= '0;
            zero_r      <= 1'b1;
            carry_out_r <= 1'b0;
            div0_r      <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            if (is_multi) begin
                hi_reg <= '0;
                a_reg  <= accept_div ? bus.operandB : bus.operandA;
                lo_reg <= accept_div ? bus.operandA : bus.operandB;
            end else begin
                result_r    <= sc_res;
                result_hi_r <= '0;
                zero_r      <= (sc_res == '0);
                carry_out_r <= sc_co;
                div0_r      <= 1'b0;
            end
        end else if (state == RUN) begin
            cnt    <= cnt + 1'b1;
            hi_reg <= hi_n;
            lo_reg <= lo_n;
            if (cnt == LAST) begin
                result_r    <= lo_n;
                result_hi_r <= hi_n;
                zero_r      <= (lo_n == '0);
                carry_out_r <= 1'b0;
                div0_r      <= div0_n;
            end
        end
    end

    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.zero      = zero_r;
    assign bus.carry_out = carry_out_r;
    assign bus.div0      = div0_r;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - scoreboard bench for mc_alu with directed vectors
module tb_mc_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(W)) bus ();
    mc_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         co;
        logic         d0;
        string        name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"},    {32'd0, bus.result},    {32'd0, e.res});
                check({e.name, "_result_hi"}, {32'd0, bus.result_hi}, {32'd0, e.hi});
                check({e.name, "_zero"},      {63'd0, bus.zero},      {63'd0, e.z});
                check({e.name, "_carry_out"}, {63'd0, bus.carry_out}, {63'd0, e.co});
                check({e.name, "_div0"},      {63'd0, bus.div0},      {63'd0, e.d0});
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic ez, input logic eco, input logic ed0, input int lat);
        exp_t e;
        int cycles;
        int busy_cnt;
        e.res = er; e.hi = eh; e.z = ez; e.co = eco; e.d0 = ed0; e.name = name;
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.operandA = a;
        bus.operandB = b;
        bus.carry_in = cin;
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.operandA = ~a;
            bus.operandB = ~b;
            cycles++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && cycles < 200);
        check({name, "_latency"}, 64'(cycles), 64'(lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    endtask

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, SLT_ = 4'b0011;
    localparam logic [3:0] SUB_ = 4'b0110, PASSB_ = 4'b0111, MULU_ = 4'b1000, DIVU_ = 4'b1001;

    initial begin
        exp_t e;
        bus.start = 1'b0; bus.op = '0; bus.operandA = '0; bus.operandB = '0; bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        check("rst_zero", {63'd0, bus.zero}, 64'd1);
        rst = 1'b0;

        run_op("add_wrap", ADD_, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        run_op("sub_neg",  SUB_, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("slt_lt",   SLT_, 32'd5, 32'd7, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("slt_sgn",  SLT_, 32'h8000_0000, 32'h1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        run_op("sub_cin",  SUB_, 32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("add_cin",  ADD_, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("and_op",   AND_, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b0, 32'h0A0A_0505, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("or_op",    OR_, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("dflt_and", 4'b1111, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1, 32'h0F00_0F00, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("mul_max",  MULU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33);
        run_op("mul_small", MULU_, 32'd3, 32'd5, 1'b1, 32'd15, 32'h0, 1'b0, 1'b0, 1'b0, 33);
        run_op("mul_hionly", MULU_, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 33);
`ifdef MC_ALU_DIV_EN
        run_op("div_100_7", DIVU_, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33);
        run_op("div_by0",   DIVU_, 32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 1'b1, 33);
`else
        run_op("div_off",   DIVU_, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
`endif

        // Back-to-back: ADD then OR accepted on consecutive edges
        @(negedge clk);
        e.res = 32'd6; e.hi = '0; e.z = 1'b0; e.co = 1'b0; e.d0 = 1'b0; e.name = "b2b_add";
        sb.push_back(e);
        bus.start = 1'b1; bus.op = ADD_; bus.operandA = 32'd2; bus.operandB = 32'd3; bus.carry_in = 1'b1;
        @(negedge clk);
        check("b2b_done1", {63'd0, bus.done}, 64'd1);
        e.res = 32'h00FF_FF00; e.co = 1'b0; e.name = "b2b_or";
        sb.push_back(e);
        bus.op = OR_; bus.operandA = 32'h00FF_0000; bus.operandB = 32'h0000_FF00;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_done2", {63'd0, bus.done}, 64'd1);
        @(negedge clk);
        check("b2b_done_end", {63'd0, bus.done}, 64'd0);

        run_op("passb", PASSB_, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 1);

        // Reset mid-RUN with an ignored start pulse in between
        @(negedge clk);
        bus.start = 1'b1; bus.op = MULU_; bus.operandA = 32'hFFFF_FFFF; bus.operandB = 32'h3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 5) begin bus.start = 1'b1; bus.op = ADD_; end
            if (i == 6) bus.start = 1'b0;
            if (i == 9) check("midrun_busy", {63'd0, bus.busy}, 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_result", {32'd0, bus.result}, 64'd0);
        check("arst_result_hi", {32'd0, bus.result_hi}, 64'd0);
        check("arst_zero", {63'd0, bus.zero}, 64'd1);
        check("arst_carry_out", {63'd0, bus.carry_out}, 64'd0);
        check("arst_div0", {63'd0, bus.div0}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_add", ADD_, 32'd10, 32'd20, 1'b0, 32'd30, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("post_rst_mul", MULU_, 32'd7, 32'd9, 1'b0, 32'd63, 32'h0, 1'b0, 1'b0, 1'b0, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
